// File: rtl/bus_rr_xfer_pkg.sv
// Shared types and dest-decoding helpers for the round-robin transfer bus.
package bus_rr_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } bus_state_t;

  // Dest equal to the processor count addresses every processor except the source.
  function automatic logic is_broadcast(input int unsigned dest, input int unsigned num_proc);
    return dest == num_proc;
  endfunction

  function automatic logic dest_valid(input int unsigned dest, input int unsigned num_proc);
    return dest <= num_proc;
  endfunction

endpackage

// File: rtl/bus_rr_xfer_if.sv
// Request/grant/delivery signals between the processors and the shared bus.
interface bus_rr_xfer_if #(
  parameter int unsigned NUM_PROC = 4
);
  localparam int unsigned IDX_W  = $clog2(NUM_PROC);
  localparam int unsigned DEST_W = IDX_W + 1;

  logic [NUM_PROC-1:0]             request;
  logic [NUM_PROC-1:0][DEST_W-1:0] request_dest;
  logic [NUM_PROC-1:0]             request_grant;
  logic                            processed_request;
  logic [NUM_PROC-1:0]             request_avail;
  logic                            drop_err;
  logic                            busy;
  logic [IDX_W-1:0]                owner;

  modport master (
    output request, request_dest,
    input  request_grant, processed_request, request_avail, drop_err, busy, owner
  );

  modport slave (
    input  request, request_dest,
    output request_grant, processed_request, request_avail, drop_err, busy, owner
  );

endinterface

// File: rtl/bus_rr_xfer_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, wrapping mod N.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] sel;

  // ptr itself is scanned last, so the previous winner has lowest priority.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    sel        = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      sel = IDX_W'((32'(ptr) + off) % N);
      if (!found && req[sel]) begin
        found           = 1'b1;
        gnt_idx         = sel;
        gnt_onehot[sel] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_rr_xfer.sv
// Shared bus: round-robin arbitration, fixed BUS_CYCLES occupancy, unicast/broadcast delivery.
module bus_rr_xfer
  import bus_rr_xfer_pkg::*;
#(
  parameter int unsigned NUM_PROC   = 4,
  parameter int unsigned BUS_CYCLES = 3
) (
  input logic          clk,
  input logic          rst,
  bus_rr_xfer_if.slave bus
);

  localparam int unsigned     IDX_W    = $clog2(NUM_PROC);
  localparam int unsigned     DEST_W   = IDX_W + 1;
  localparam int unsigned     CNT_W    = $clog2(BUS_CYCLES + 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_PROC - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUS_CYCLES - 1);

  bus_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_PROC-1:0] grant_q, grant_d;
  logic [NUM_PROC-1:0] avail_q, avail_d;
  logic                processed_q, processed_d;
  logic                drop_err_q, drop_err_d;
  logic                busy_q, busy_d;

  logic [NUM_PROC-1:0] arb_onehot;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  rr_arbiter #(.N(NUM_PROC)) u_arb (
    .req        (bus.request),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // Next-state and output decode; pulses default low and last one cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dest_d      = dest_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = '0;
    avail_d     = '0;
    processed_d = 1'b0;
    drop_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_onehot;
          owner_d  = arb_idx;
          rr_ptr_d = arb_idx;
          dest_d   = bus.request_dest[arb_idx];
          cnt_d    = CNT_LOAD;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          processed_d = 1'b1;
          if (!dest_valid(32'(dest_q), NUM_PROC)) begin
            drop_err_d = 1'b1;
          end else if (is_broadcast(32'(dest_q), NUM_PROC)) begin
            avail_d = ~(NUM_PROC'(1) << owner_q);
          end else begin
            avail_d = NUM_PROC'(1) << dest_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dest_q      <= '0;
      rr_ptr_q    <= PTR_RST;
      owner_q     <= '0;
      grant_q     <= '0;
      avail_q     <= '0;
      processed_q <= 1'b0;
      drop_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_q      <= dest_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      avail_q     <= avail_d;
      processed_q <= processed_d;
      drop_err_q  <= drop_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.request_grant     = grant_q;
  assign bus.request_avail     = avail_q;
  assign bus.processed_request = processed_q;
  assign bus.drop_err          = drop_err_q;
  assign bus.busy              = busy_q;
  assign bus.owner             = owner_q;

endmodule

// File: tb/tb_bus_rr_xfer.sv
// Directed + random bench for bus_rr_xfer against a transaction-schedule reference model.
module tb_bus_rr_xfer;

  localparam int unsigned NP    = 4;
  localparam int unsigned BC    = 3;
  localparam int unsigned DW    = 3;
  localparam int          SLOTS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_rr_xfer_if #(.NUM_PROC(NP)) bus_if ();

  bus_rr_xfer #(.NUM_PROC(NP), .BUS_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Reference model: each accepted request books a future schedule of expected pulses.
  int           e = 0;
  int           next_arb = 0;
  int           m_ptr = NP - 1;
  int           m_owner = 0;
  int           last_win = -1;
  bit [NP-1:0]  x_grant [SLOTS];
  bit [NP-1:0]  x_avail [SLOTS];
  bit           x_proc  [SLOTS];
  bit           x_drop  [SLOTS];
  bit           x_busy  [SLOTS];
  int           grant_log [$];
  int           checks = 0;
  int           errors = 0;

  task automatic clear_slot(input int s);
    x_grant[s] = '0;
    x_avail[s] = '0;
    x_proc[s]  = 1'b0;
    x_drop[s]  = 1'b0;
    x_busy[s]  = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    int d;
    int s;
    last_win = -1;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) clear_slot(i);
      m_ptr    = NP - 1;
      m_owner  = 0;
      next_arb = e + 1;
    end else if (e >= next_arb && bus_if.request != '0) begin
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (m_ptr + k) % NP;
        if (last_win < 0 && bus_if.request[c]) last_win = c;
      end
      w = last_win;
      d = int'(bus_if.request_dest[w]);
      x_grant[e % SLOTS][w] = 1'b1;
      for (int t = 0; t <= BC; t++) x_busy[(e + t) % SLOTS] = 1'b1;
      s = (e + BC) % SLOTS;
      x_proc[s] = 1'b1;
      x_drop[s] = (d > NP);
      for (int i = 0; i < NP; i++)
        x_avail[s][i] = (d < NP && i == d) || (d == NP && i != w);
      m_ptr    = w;
      m_owner  = w;
      next_arb = e + BC + 2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int s;
    s = e % SLOTS;
    chk("grant",     32'(bus_if.request_grant),     32'(x_grant[s]));
    chk("processed", 32'(bus_if.processed_request), 32'(x_proc[s]));
    chk("avail",     32'(bus_if.request_avail),     32'(x_avail[s]));
    chk("drop_err",  32'(bus_if.drop_err),          32'(x_drop[s]));
    chk("busy",      32'(bus_if.busy),              32'(x_busy[s]));
    chk("owner",     32'(bus_if.owner),             32'(m_owner));
    for (int i = 0; i < NP; i++)
      if (bus_if.request_grant[i] === 1'b1) grant_log.push_back(i);
    clear_slot(s);
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    model_edge();
    #1;
    check_outputs();
  endtask

  // Run n cycles; a granted requester drops its line unless hold is set.
  task automatic run_cycles(input int n, input bit hold);
    repeat (n) begin
      tick();
      if (last_win >= 0 && !hold) bus_if.request[last_win] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.request      = '0;
    bus_if.request_dest = '0;
    tick();
    tick();
    chk("reset_busy",  32'(bus_if.busy),  32'd0);
    chk("reset_owner", 32'(bus_if.owner), 32'd0);
    rst = 1'b0;

    // Unicast to proc 2: grant next cycle, delivery BUS_CYCLES later.
    bus_if.request[0]      = 1'b1;
    bus_if.request_dest[0] = DW'(2);
    tick();
    chk("t1_grant", 32'(bus_if.request_grant), 32'b0001);
    bus_if.request[0]      = 1'b0;
    bus_if.request_dest[0] = DW'(1);
    run_cycles(3, 1'b0);
    chk("t1_avail", 32'(bus_if.request_avail),     32'b0100);
    chk("t1_proc",  32'(bus_if.processed_request), 32'd1);
    tick();

    // Broadcast from proc 1.
    bus_if.request[1]      = 1'b1;
    bus_if.request_dest[1] = DW'(4);
    tick();
    bus_if.request[1] = 1'b0;
    run_cycles(3, 1'b0);
    chk("t2_avail", 32'(bus_if.request_avail), 32'b1101);
    chk("t2_drop",  32'(bus_if.drop_err),      32'd0);
    tick();

    // All four request, two rounds: strict rotation from proc 0.
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NP; i++) begin
        bus_if.request[i]      = 1'b1;
        bus_if.request_dest[i] = DW'((i + 1) % NP);
      end
      run_cycles(4 * (BC + 2), 1'b0);
    end
    chk("t3_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("t3_order", 32'(grant_log[k]), 32'(k % NP));

    // Out-of-range dest is dropped with an error.
    bus_if.request[2]      = 1'b1;
    bus_if.request_dest[2] = DW'(6);
    tick();
    bus_if.request[2] = 1'b0;
    run_cycles(3, 1'b0);
    chk("t4_proc",  32'(bus_if.processed_request), 32'd1);
    chk("t4_drop",  32'(bus_if.drop_err),          32'd1);
    chk("t4_avail", 32'(bus_if.request_avail),     32'd0);
    tick();
    chk("t4_idle",  32'(bus_if.busy),              32'd0);

    // Reset during XFER abandons the transfer and restores proc-0 priority.
    bus_if.request[1]      = 1'b1;
    bus_if.request_dest[1] = DW'(0);
    tick();
    bus_if.request[1] = 1'b0;
    tick();
    do_reset();
    chk("t5_busy", 32'(bus_if.busy), 32'd0);
    for (int i = 0; i < BC + 1; i++) begin
      tick();
      chk("t5_noproc", 32'(bus_if.processed_request), 32'd0);
    end
    bus_if.request[3]      = 1'b1;
    bus_if.request_dest[3] = DW'(1);
    bus_if.request[0]      = 1'b1;
    bus_if.request_dest[0] = DW'(3);
    tick();
    chk("t5_grant0", 32'(bus_if.request_grant), 32'b0001);
    bus_if.request[0] = 1'b0;
    run_cycles(BC + 2, 1'b0);
    chk("t5_grant3", 32'(bus_if.owner), 32'd3);
    run_cycles(BC + 1, 1'b0);

    // Two held requests alternate.
    do_reset();
    grant_log.delete();
    bus_if.request         = 4'b0011;
    bus_if.request_dest[0] = DW'(2);
    bus_if.request_dest[1] = DW'(3);
    run_cycles(4 * (BC + 2), 1'b1);
    bus_if.request = '0;
    chk("t6_count", 32'(grant_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk("t6_order", 32'(grant_log[k]), 32'(k % 2));
    run_cycles(BC + 2, 1'b0);

    // Random traffic, occasional held requests, dest changes after grant, resets.
    repeat (600) begin
      for (int i = 0; i < NP; i++) begin
        if (!bus_if.request[i] && $urandom_range(0, 3) == 0) begin
          bus_if.request[i]      = 1'b1;
          bus_if.request_dest[i] = DW'($urandom_range(0, 7));
        end else if (bus_if.request[i] && $urandom_range(0, 15) == 0) begin
          bus_if.request[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      rst = 1'b0;
      if (last_win >= 0) begin
        if ($urandom_range(0, 3) != 0) bus_if.request[last_win] = 1'b0;
        bus_if.request_dest[last_win] = DW'($urandom_range(0, 7));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
